// File: rtl/ebi_bridge_pkg.sv
// ebi_write_bridge shared types.
// Command bundle, FSM state and status word layout.
package ebi_bridge_pkg;

  typedef struct packed {
    logic [2:0]  bank;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    READ
  } ebi_state_t;

  localparam logic [2:0] BANK_OAM     = 3'd0;
  localparam logic [2:0] BANK_SPRITE  = 3'd1;
  localparam logic [2:0] BANK_TAM     = 3'd2;
  localparam logic [2:0] BANK_PALETTE = 3'd3;

  localparam int STATUS_OVF_BIT = 15;

  function automatic logic [15:0] status_word(
    input logic       ovf,
    input logic [7:0] lvl
  );
    logic [15:0] s;
    s = '0;
    s[STATUS_OVF_BIT] = ovf;
    s[7:0] = lvl;
    return s;
  endfunction

endpackage

// File: rtl/ebi_write_bridge_fifo.sv
// Synchronous write-command FIFO.
// A push on full only lands if a pop frees a slot that same cycle.
import ebi_bridge_pkg::*;

module cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  wr_cmd_t                  din,
  input  logic                     pop,
  output wr_cmd_t                  dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  wr_cmd_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == LW'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign dout  = mem[rd_ptr];
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + LW'(wr_en) - LW'(rd_en);
    end
  end

endmodule

// File: rtl/ebi_write_bridge.sv
// EBI write bridge: async MCU bus to clk_100m write commands.
// Reads return {overflow, 7'b0, occupancy}.
import ebi_bridge_pkg::*;

module ebi_write_bridge #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AUTO_INC    = 1
) (
  input  logic        clk_100m,
  input  logic        btn_rst,
  input  logic [15:0] ebi_ad_in,
  output logic [15:0] ebi_ad_out,
  output logic        ebi_ad_oe,
  input  logic        ebi_ale,
  input  logic        ebi_we,
  input  logic        ebi_re,
  input  logic [2:0]  bank_select,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [2:0]  wr_bank,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        overflow
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic        ale;
    logic        we;
    logic        re;
    logic [2:0]  bank;
    logic [15:0] ad;
  } pins_t;

  pins_t      sync_q [SYNC_STAGES];
  pins_t      s;
  logic       ale_p, we_p, re_p;
  logic       ale_fall, ale_rise, we_rise;
  logic       re_fall, re_rise;

  ebi_state_t  state;
  logic [15:0] addr_reg;
  logic [2:0]  bank_reg;
  logic        push_q;
  wr_cmd_t     push_cmd;
  wr_cmd_t     head;
  logic        full, empty, pop, ovf_set;
  logic [LW-1:0] level;
  logic [15:0] status;

  assign s = sync_q[SYNC_STAGES-1];

  // AD rides the same chain as the strobes so it stays aligned.
  always_ff @(posedge clk_100m or negedge btn_rst) begin
    if (!btn_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      ale_p <= 1'b0;
      we_p  <= 1'b0;
      re_p  <= 1'b0;
    end else begin
      sync_q[0] <= '{ale: ebi_ale, we: ebi_we, re: ebi_re,
                     bank: bank_select, ad: ebi_ad_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      ale_p <= s.ale;
      we_p  <= s.we;
      re_p  <= s.re;
    end
  end

  assign ale_fall = ale_p & ~s.ale;
  assign ale_rise = ~ale_p & s.ale;
  assign we_rise  = ~we_p & s.we;
  assign re_fall  = re_p & ~s.re;
  assign re_rise  = ~re_p & s.re;

  assign wr_valid = ~empty;
  assign pop      = wr_valid & wr_ready;
  assign ovf_set  = push_q & full & ~pop;
  assign status   = status_word(overflow, 8'(level));

  always_ff @(posedge clk_100m or negedge btn_rst) begin
    if (!btn_rst) begin
      state      <= IDLE;
      addr_reg   <= '0;
      bank_reg   <= '0;
      push_q     <= 1'b0;
      push_cmd   <= '0;
      overflow   <= 1'b0;
      ebi_ad_out <= '0;
      ebi_ad_oe  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (ovf_set) overflow <= 1'b1;
      else if (state == READ && re_rise) overflow <= 1'b0;
      unique case (state)
        IDLE: if (ale_fall) state <= ADDR;
        ADDR: begin
          if (ale_rise) begin
            addr_reg <= s.ad;
            bank_reg <= s.bank;
            state    <= DATA;
          end
        end
        DATA: begin
          if (re_fall) begin
            state      <= READ;
            ebi_ad_oe  <= 1'b1;
            ebi_ad_out <= status;
          end else if (we_rise && s.re) begin
            push_q   <= 1'b1;
            push_cmd <= '{bank: bank_reg, addr: addr_reg, data: s.ad};
            if (AUTO_INC != 0) addr_reg <= addr_reg + 16'd1;
          end else if (ale_fall) begin
            state <= ADDR;
          end
        end
        READ: begin
          ebi_ad_out <= status;
          if (re_rise) begin
            ebi_ad_oe  <= 1'b0;
            ebi_ad_out <= '0;
            state      <= DATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_100m),
    .rst_n (btn_rst),
    .push  (push_q),
    .din   (push_cmd),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign wr_bank = head.bank;
  assign wr_addr = head.addr;
  assign wr_data = head.data;

endmodule

// File: tb/tb_ebi_write_bridge.sv
// Scoreboard bench for ebi_write_bridge.
// Stimulus pushes expected commands; a negedge monitor checks them.
import ebi_bridge_pkg::*;

module tb_ebi_write_bridge;

  logic        clk_100m = 1'b0;
  logic        btn_rst = 1'b0;
  logic [15:0] ebi_ad_in = '0;
  logic [15:0] ebi_ad_out;
  logic        ebi_ad_oe;
  logic        ebi_ale = 1'b1;
  logic        ebi_we = 1'b1;
  logic        ebi_re = 1'b1;
  logic [2:0]  bank_select = '0;
  logic        wr_valid;
  logic        wr_ready = 1'b0;
  logic [2:0]  wr_bank;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        overflow;

  int total = 0;
  int bad = 0;
  wr_cmd_t exp_q [$];
  logic bp_done;

  always #5 clk_100m = ~clk_100m;

  ebi_write_bridge #(
    .FIFO_DEPTH(4), .SYNC_STAGES(2), .AUTO_INC(1)
  ) dut (
    .clk_100m(clk_100m), .btn_rst(btn_rst),
    .ebi_ad_in(ebi_ad_in), .ebi_ad_out(ebi_ad_out),
    .ebi_ad_oe(ebi_ad_oe), .ebi_ale(ebi_ale),
    .ebi_we(ebi_we), .ebi_re(ebi_re),
    .bank_select(bank_select), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .overflow(overflow)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk_100m) begin
    if (btn_rst && wr_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected actual=%h/%h/%h required=none",
                 wr_bank, wr_addr, wr_data);
      end else begin
        if ({wr_bank, wr_addr, wr_data} !== exp_q[0]) begin
          bad++;
          $display("FAIL sb_cmd actual=%h/%h/%h required=%h/%h/%h",
                   wr_bank, wr_addr, wr_data, exp_q[0].bank,
                   exp_q[0].addr, exp_q[0].data);
        end
        if (wr_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_100m);
      #2;
    end
  endtask

  task automatic expect_cmd(input logic [2:0] b, input logic [15:0] a,
                            input logic [15:0] d);
    exp_q.push_back('{bank: b, addr: a, data: d});
  endtask

  task automatic ebi_addr(input logic [2:0] b, input logic [15:0] a);
    ebi_ad_in = a;
    bank_select = b;
    ebi_ale = 1'b0;
    cyc(5);
    ebi_ale = 1'b1;
    cyc(5);
  endtask

  task automatic we_pulse(input logic [15:0] d);
    ebi_ad_in = d;
    cyc(4);
    ebi_we = 1'b0;
    cyc(5);
    ebi_we = 1'b1;
  endtask

  task automatic ebi_write(input logic [15:0] d);
    we_pulse(d);
    cyc(5);
  endtask

  task automatic ebi_read(output logic [15:0] st, output logic oe);
    ebi_re = 1'b0;
    cyc(6);
    st = ebi_ad_out;
    oe = ebi_ad_oe;
    ebi_re = 1'b1;
    cyc(6);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk_100m);
      n++;
    end
    #2;
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    logic [15:0] st;
    logic oe;
    cyc(3);
    chk("rst_valid", wr_valid, 0);
    chk("rst_bank", wr_bank, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_adout", ebi_ad_out, 0);
    chk("rst_oe", ebi_ad_oe, 0);
    btn_rst = 1'b1;
    cyc(4);

    // single write with latency check
    wr_ready = 1'b1;
    expect_cmd(3'd3, 16'h0040, 16'h7C1F);
    ebi_addr(3'd3, 16'h0040);
    we_pulse(16'h7C1F);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk_100m);
      #1;
      chk($sformatf("lat_edge%0d", k), wr_valid, (k == 4));
    end
    cyc(5);
    drain("single_drain");

    // burst with address wrap
    expect_cmd(BANK_OAM, 16'hFFFE, 16'd1);
    expect_cmd(BANK_OAM, 16'hFFFF, 16'd2);
    expect_cmd(BANK_OAM, 16'h0000, 16'd3);
    ebi_addr(BANK_OAM, 16'hFFFE);
    ebi_write(16'd1);
    ebi_write(16'd2);
    ebi_write(16'd3);
    drain("burst_drain");

    // overflow
    wr_ready = 1'b0;
    ebi_addr(BANK_SPRITE, 16'h0100);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_cmd(BANK_SPRITE, 16'h0100 + 16'(i), 16'(10 + i));
      ebi_write(16'(10 + i));
    end
    chk("ovf_set", overflow, 1);
    ebi_read(st, oe);
    chk("ovf_status", st, 16'h8004);
    chk("ovf_rd_oe", oe, 1);
    chk("ovf_clear", overflow, 0);
    chk("ovf_oe_off", ebi_ad_oe, 0);
    wr_ready = 1'b1;
    drain("ovf_drain");

    // backpressure burst
    wr_ready = 1'b0;
    bp_done = 1'b0;
    ebi_addr(BANK_SPRITE, 16'h0300);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          expect_cmd(BANK_SPRITE, 16'h0300 + 16'(i), 16'h0011 + 16'(i));
          ebi_write(16'h0011 + 16'(i));
        end
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk_100m);
          #2;
          wr_ready = ~wr_ready;
        end
      end
    join
    wr_ready = 1'b1;
    drain("bp_drain");

    // full FIFO with simultaneous pop
    wr_ready = 1'b0;
    ebi_addr(BANK_TAM, 16'h0200);
    for (int i = 0; i < 5; i++) expect_cmd(BANK_TAM, 16'h0200 + 16'(i), 16'h00A0 + 16'(i));
    for (int i = 0; i < 4; i++) ebi_write(16'h00A0 + 16'(i));
    we_pulse(16'h00A4);
    repeat (3) @(posedge clk_100m);
    #2;
    wr_ready = 1'b1;
    @(posedge clk_100m);
    #1;
    wr_ready = 1'b0;
    chk("fullpop_ovf", overflow, 0);
    cyc(5);
    ebi_read(st, oe);
    chk("fullpop_status", st, 16'h0004);
    wr_ready = 1'b1;
    drain("fullpop_drain");

    // reset mid-burst
    wr_ready = 1'b0;
    ebi_addr(3'd4, 16'h0500);
    expect_cmd(3'd4, 16'h0500, 16'h0001);
    expect_cmd(3'd4, 16'h0501, 16'h0002);
    ebi_write(16'h0001);
    ebi_write(16'h0002);
    chk("prerst_valid", wr_valid, 1);
    btn_rst = 1'b0;
    exp_q.delete();
    #1;
    chk("mrst_valid", wr_valid, 0);
    chk("mrst_bank", wr_bank, 0);
    chk("mrst_addr", wr_addr, 0);
    chk("mrst_data", wr_data, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_oe", ebi_ad_oe, 0);
    cyc(3);
    btn_rst = 1'b1;
    cyc(3);
    wr_ready = 1'b1;
    ebi_write(16'h0055);
    cyc(10);
    chk("idle_we_ignored", wr_valid, 0);

    expect_cmd(BANK_PALETTE, 16'h0010, 16'h0066);
    ebi_addr(BANK_PALETTE, 16'h0010);
    ebi_write(16'h0066);
    drain("recover_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
